// File: rtl/timer_intc_pkg.sv
// Shared definitions for the timer / interrupt controller: register map,
// CTRL bit positions and the interrupt handshake state encoding.
package timer_intc_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_PERIOD = 3'd1;
  localparam logic [2:0] ADDR_COUNT  = 3'd2;
  localparam logic [2:0] ADDR_MASK   = 3'd3;
  localparam logic [2:0] ADDR_EDGE   = 3'd4;
  localparam logic [2:0] ADDR_PEND   = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_TMR_IE  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACKLOW
  } int_state_e;

endpackage

// File: rtl/timer_intc_irq_sync_edge.sv
// Two-flop synchronizer for asynchronous IRQ pins followed by a rising-edge
// detector; provides both the synced level and a one-cycle rise pulse.
module irq_sync_edge #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] irq_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = irq_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/timer_intc_n.sv
// System timer plus fixed-priority interrupt controller with a bus-mapped
// register file and an INT/INT_ACK handshake towards the core.
module timer_intc_n
  import timer_intc_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned ID_W    = $clog2(NUM_SRC + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               DREQ,
  input  logic               DRW,
  input  logic [2:0]         DADDR,
  input  logic [DATA_W-1:0]  WDATA,
  output logic [DATA_W-1:0]  RDATA,
  output logic               DRDY,
  input  logic [NUM_SRC-1:0] SRC_IRQ,
  output logic               INT,
  output logic [ID_W-1:0]    INT_ID,
  input  logic               INT_ACK
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              en_q, en_d, oneshot_q, oneshot_d, tmr_ie_q, tmr_ie_d;
  logic [CNT_W-1:0]  period_q, period_d, count_q, count_d;
  logic [NUM_SRC:0]  mask_q, mask_d, edge_mode_q, edge_mode_d, pend_q, pend_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              drdy_q, drdy_d;
  int_state_e        state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic [NUM_SRC-1:0] src_level, src_rise;
  logic               wr, rd, match, ack, any_elig;
  logic [NUM_SRC:0]   eligible, is_level, hw_set, clr;
  logic [ID_W-1:0]    win_id;
  logic               unused_wdata;

  irq_sync_edge #(.WIDTH(NUM_SRC)) u_sync (
    .CLK     (CLK),
    .RST     (RST),
    .irq_i   (SRC_IRQ),
    .level_o (src_level),
    .rise_o  (src_rise)
  );

  assign wr           = DREQ & DRW;
  assign rd           = DREQ & ~DRW;
  assign match        = en_q && (period_q != '0) && (count_q == period_q);
  assign unused_wdata = ^WDATA;

  // Timer and configuration registers; a bus write to CTRL overrides the one-shot stop.
  always_comb begin
    en_d        = en_q;
    oneshot_d   = oneshot_q;
    tmr_ie_d    = tmr_ie_q;
    period_d    = period_q;
    mask_d      = mask_q;
    edge_mode_d = edge_mode_q;
    if (match && oneshot_q) en_d = 1'b0;
    if (wr) begin
      unique case (DADDR)
        ADDR_CTRL: begin
          en_d      = WDATA[CTRL_EN];
          oneshot_d = WDATA[CTRL_ONESHOT];
          tmr_ie_d  = WDATA[CTRL_TMR_IE];
        end
        ADDR_PERIOD: period_d    = WDATA[CNT_W-1:0];
        ADDR_MASK:   mask_d      = WDATA[NUM_SRC:0];
        ADDR_EDGE:   edge_mode_d = {WDATA[NUM_SRC:1], 1'b0};
        default: ;
      endcase
    end
    if (wr && DADDR == ADDR_PERIOD) count_d = CNT_ONE;
    else if (!en_q || match || count_q == '1) count_d = CNT_ONE;
    else count_d = count_q + CNT_ONE;
  end

  // Fixed-priority pick: lowest ID wins; the timer also needs TMR_IE.
  always_comb begin
    eligible    = pend_q & mask_q;
    eligible[0] = pend_q[0] & mask_q[0] & tmr_ie_q;
    any_elig    = |eligible;
    win_id      = '0;
    for (int unsigned i = NUM_SRC + 1; i > 0; i--) begin
      if (eligible[i-1]) win_id = ID_W'(i - 1);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ack     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!INT_ACK && any_elig) begin
          state_d = ST_REQ;
          id_d    = win_id;
        end
      end
      ST_REQ: begin
        if (INT_ACK) begin
          state_d = ST_WAIT_ACKLOW;
          ack     = 1'b1;
        end
      end
      ST_WAIT_ACKLOW: if (!INT_ACK) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Edge-type bits (timer included): set beats clear. Level bits just track the synced pin.
  always_comb begin
    is_level    = ~edge_mode_q;
    is_level[0] = 1'b0;
    hw_set      = {src_rise, match} & ~is_level;
    clr         = '0;
    if (wr && DADDR == ADDR_PEND) clr = WDATA[NUM_SRC:0];
    if (ack) clr[id_q] = 1'b1;
    pend_d = (pend_q & ~clr) | hw_set;
    pend_d = (pend_d & ~is_level) | ({src_level, 1'b0} & is_level);
  end

  always_comb begin
    rdata_d = rdata_q;
    drdy_d  = ~wr;
    if (rd) begin
      rdata_d = '0;
      unique case (DADDR)
        ADDR_CTRL: begin
          rdata_d[CTRL_EN]      = en_q;
          rdata_d[CTRL_ONESHOT] = oneshot_q;
          rdata_d[CTRL_TMR_IE]  = tmr_ie_q;
        end
        ADDR_PERIOD: rdata_d[CNT_W-1:0]   = period_q;
        ADDR_COUNT:  rdata_d[CNT_W-1:0]   = count_q;
        ADDR_MASK:   rdata_d[NUM_SRC:0]   = mask_q;
        ADDR_EDGE:   rdata_d[NUM_SRC:0]   = edge_mode_q;
        ADDR_PEND:   rdata_d[NUM_SRC:0]   = pend_q;
        ADDR_STATUS: begin
          rdata_d[ID_W-1:0]   = id_q;
          rdata_d[DATA_W-1]   = (state_q == ST_REQ);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      en_q        <= 1'b0;
      oneshot_q   <= 1'b0;
      tmr_ie_q    <= 1'b0;
      period_q    <= '0;
      count_q     <= CNT_ONE;
      mask_q      <= '0;
      edge_mode_q <= '0;
      pend_q      <= '0;
      rdata_q     <= '0;
      drdy_q      <= 1'b1;
      state_q     <= ST_IDLE;
      id_q        <= '0;
    end else begin
      en_q        <= en_d;
      oneshot_q   <= oneshot_d;
      tmr_ie_q    <= tmr_ie_d;
      period_q    <= period_d;
      count_q     <= count_d;
      mask_q      <= mask_d;
      edge_mode_q <= edge_mode_d;
      pend_q      <= pend_d;
      rdata_q     <= rdata_d;
      drdy_q      <= drdy_d;
      state_q     <= state_d;
      id_q        <= id_d;
    end
  end

  assign RDATA  = rdata_q;
  assign DRDY   = drdy_q;
  assign INT    = (state_q == ST_REQ);
  assign INT_ID = id_q;

endmodule

// File: tb/tb_timer_intc_n.sv
// Bench for timer_intc_n: directed scenarios plus random traffic, compared
// every cycle against a per-bit rule model of the register/interrupt behaviour.
module tb_timer_intc_n;

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic               CLK = 1'b0;
  logic               RST, DREQ, DRW, DRDY, INT, INT_ACK;
  logic [2:0]         DADDR;
  logic [DATA_W-1:0]  WDATA, RDATA;
  logic [NUM_SRC-1:0] SRC_IRQ;
  logic [ID_W-1:0]    INT_ID;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  timer_intc_n #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .WDATA(WDATA),
    .RDATA(RDATA), .DRDY(DRDY), .SRC_IRQ(SRC_IRQ), .INT(INT), .INT_ID(INT_ID),
    .INT_ACK(INT_ACK)
  );

  // Reference state
  bit                m_en, m_os, m_ie, m_int, m_wait, m_drdy;
  int unsigned       m_period, m_count, m_id;
  bit [NUM_SRC:0]    m_mask, m_edge, m_pend;
  bit [DATA_W-1:0]   m_rdata;
  bit [NUM_SRC-1:0]  h1, h2, h3;   // pin samples from the last three edges

  function automatic int unsigned lowest(input bit [NUM_SRC:0] v);
    for (int unsigned k = 0; k <= NUM_SRC; k++) if (v[k]) return k;
    return 0;
  endfunction

  task automatic model_reset();
    m_en = 0; m_os = 0; m_ie = 0; m_period = 0; m_count = 1;
    m_mask = '0; m_edge = '0; m_pend = '0; m_rdata = '0; m_drdy = 1;
    m_int = 0; m_wait = 0; m_id = 0; h1 = '0; h2 = '0; h3 = '0;
  endtask

  task automatic model_step();
    bit wr, rd, match, ack, set, clear, n_en, n_int, n_wait;
    int unsigned addr, n_count, n_id;
    bit [NUM_SRC:0] elig, n_pend;
    bit [DATA_W-1:0] rd_val;
    wr = DREQ && DRW; rd = DREQ && !DRW; addr = 32'(DADDR);
    match = m_en && m_period != 0 && m_count == m_period;
    ack = m_int && INT_ACK;
    rd_val = '0;
    case (addr)
      0: begin rd_val[0] = m_en; rd_val[1] = m_os; rd_val[2] = m_ie; end
      1: rd_val = m_period;
      2: rd_val = m_count;
      3: rd_val = DATA_W'(m_mask);
      4: rd_val = DATA_W'(m_edge);
      5: rd_val = DATA_W'(m_pend);
      6: begin rd_val = m_id; rd_val[DATA_W-1] = m_int; end
      default: rd_val = '0;
    endcase
    // Timer
    if (wr && addr == 1) n_count = 1;
    else if (!m_en || match || m_count == CNT_MAX) n_count = 1;
    else n_count = m_count + 1;
    n_en = m_en;
    if (match && m_os) n_en = 0;
    // Pending bits
    for (int unsigned b = 0; b <= NUM_SRC; b++) begin
      if (b != 0 && !m_edge[b]) n_pend[b] = h2[b-1];
      else begin
        set   = (b == 0) ? match : (h2[b-1] && !h3[b-1]);
        clear = (wr && addr == 5 && WDATA[b]) || (ack && m_id == b);
        n_pend[b] = set ? 1'b1 : (clear ? 1'b0 : m_pend[b]);
      end
    end
    // Handshake
    elig = m_pend & m_mask;
    if (!m_ie) elig[0] = 0;
    n_int = m_int; n_wait = m_wait; n_id = m_id;
    if (m_int) begin
      if (INT_ACK) begin n_int = 0; n_wait = 1; end
    end else if (m_wait) begin
      if (!INT_ACK) n_wait = 0;
    end else if (!INT_ACK && elig != '0) begin
      n_int = 1; n_id = lowest(elig);
    end
    // Commit
    if (wr) begin
      case (addr)
        0: begin n_en = WDATA[0]; m_os = WDATA[1]; m_ie = WDATA[2]; end
        1: m_period = WDATA & CNT_MAX;
        3: m_mask = WDATA[NUM_SRC:0];
        4: begin m_edge = WDATA[NUM_SRC:0]; m_edge[0] = 0; end
        default: ;
      endcase
    end
    if (rd) m_rdata = rd_val;
    m_drdy = !wr;
    m_en = n_en; m_count = n_count; m_pend = n_pend;
    m_int = n_int; m_wait = n_wait; m_id = n_id;
    h3 = h2; h2 = h1; h1 = SRC_IRQ;
  endtask

  always @(posedge CLK) begin
    if (RST) model_reset();
    else model_step();
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    chk("int", 32'(INT), 32'(m_int));
    chk("int_id", 32'(INT_ID), m_id);
    chk("drdy", 32'(DRDY), 32'(m_drdy));
    chk("rdata", RDATA, m_rdata);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [DATA_W-1:0] d);
    DREQ = 1; DRW = 1; DADDR = a; WDATA = d;
    step();
    DREQ = 0; DRW = 0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [DATA_W-1:0] v);
    DREQ = 1; DRW = 0; DADDR = a;
    step();
    DREQ = 0;
    v = RDATA;
  endtask

  task automatic wait_raise(input int unsigned exp_id);
    for (int n = 0; n < 40 && INT !== 1'b1; n++) step();
    chk("int_raised", 32'(INT), 32'd1);
    chk("int_id_exp", 32'(INT_ID), exp_id);
  endtask

  task automatic do_ack();
    INT_ACK = 1;
    step();
    INT_ACK = 0;
    chk("int_dropped", 32'(INT), 32'd0);
  endtask

  task automatic wait_int(input int unsigned exp_id);
    wait_raise(exp_id);
    do_ack();
  endtask

  task automatic quiesce();
    SRC_IRQ = '0;
    bus_write(3'd3, '0);
    bus_write(3'd0, '0);
    for (int n = 0; n < 6; n++) begin
      if (INT === 1'b1) begin INT_ACK = 1; step(); INT_ACK = 0; end
      step();
    end
    bus_write(3'd5, '1);
    repeat (3) step();
  endtask

  logic [DATA_W-1:0] v;
  logic [DATA_W-1:0] seq [0:19];
  int unsigned idx;

  initial begin
    RST = 1; DREQ = 0; DRW = 0; DADDR = '0; WDATA = '0; SRC_IRQ = '0; INT_ACK = 0;
    step(); step();
    chk("rst_int", 32'(INT), 32'd0);
    chk("rst_int_id", 32'(INT_ID), 32'd0);
    chk("rst_drdy", 32'(DRDY), 32'd1);
    chk("rst_rdata", RDATA, 32'd0);
    RST = 0;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), v);
      chk("rst_reg", v, (a == 2) ? 32'd1 : 32'd0);
    end

    // Periodic timer, period 5
    bus_write(3'd3, 32'h1);
    bus_write(3'd1, 32'd5);
    bus_write(3'd0, 32'h5);
    DREQ = 1; DRW = 0; DADDR = 3'd2;
    for (int i = 0; i < 12; i++) begin step(); seq[i] = RDATA; end
    DREQ = 0;
    chk("t1_count_first", seq[0], 32'd1);
    for (int i = 1; i < 12; i++) chk("t1_count_seq", seq[i], (seq[i-1] % 5) + 1);
    wait_int(0);
    quiesce();

    // One-shot
    bus_write(3'd1, 32'd3);
    bus_write(3'd3, 32'h1);
    bus_write(3'd0, 32'h7);
    wait_int(0);
    repeat (10) step();
    chk("t2_no_reraise", 32'(INT), 32'd0);
    bus_read(3'd0, v); chk("t2_ctrl", v, 32'h6);
    bus_read(3'd2, v); chk("t2_count_hold", v, 32'd1);
    quiesce();

    // Simultaneous level (ID1) and edge (ID2) pulses
    bus_write(3'd4, 32'h4);
    bus_write(3'd3, 32'h6);
    SRC_IRQ = 8'h03; step(); SRC_IRQ = '0;
    wait_int(1);
    wait_int(2);
    quiesce();

    // Level source ID4 re-raises until the pin drops
    bus_write(3'd4, 32'h0);
    bus_write(3'd3, 32'h10);
    SRC_IRQ[3] = 1;
    wait_int(4);
    wait_int(4);
    SRC_IRQ[3] = 0;
    repeat (5) step();
    bus_read(3'd5, v); chk("t4_pend_cleared", 32'(v[4]), 32'd0);
    chk("t4_int_held", 32'(INT), 32'd1);
    do_ack();
    repeat (6) step();
    chk("t4_quiet", 32'(INT), 32'd0);
    quiesce();

    // Edge event during active INT, W1C coinciding with the set
    bus_write(3'd4, 32'h10);
    bus_write(3'd3, 32'h12);
    SRC_IRQ[0] = 1;
    wait_raise(1);
    SRC_IRQ[3] = 1;
    step(); step();
    bus_write(3'd5, 32'h10);
    SRC_IRQ[3] = 0;
    bus_read(3'd5, v); chk("t5_set_wins", v & 32'h12, 32'h12);
    SRC_IRQ[0] = 0;
    repeat (4) step();
    do_ack();
    wait_int(4);
    quiesce();

    // Free-running wrap with PERIOD=0
    bus_write(3'd1, 32'd0);
    bus_write(3'd0, 32'h1);
    DREQ = 1; DRW = 0; DADDR = 3'd2;
    for (int i = 0; i < 20; i++) begin step(); seq[i] = RDATA; end
    DREQ = 0;
    for (int i = 1; i < 20; i++)
      chk("wrap_seq", seq[i], (seq[i-1] == CNT_MAX) ? 32'd1 : seq[i-1] + 1);
    bus_read(3'd5, v); chk("wrap_no_match", 32'(v[0]), 32'd0);
    quiesce();

    // Reset mid-handshake
    bus_write(3'd3, 32'h2);
    bus_write(3'd1, 32'd4);
    bus_write(3'd0, 32'h1);
    SRC_IRQ[0] = 1;
    wait_raise(1);
    RST = 1; step(); RST = 0;
    chk("t6_int", 32'(INT), 32'd0);
    chk("t6_drdy", 32'(DRDY), 32'd1);
    chk("t6_rdata", RDATA, 32'd0);
    bus_read(3'd5, v); chk("t6_pend", v, 32'd0);
    bus_read(3'd2, v); chk("t6_count", v, 32'd1);
    repeat (10) step();
    chk("t6_no_spurious", 32'(INT), 32'd0);
    SRC_IRQ = '0;
    repeat (4) step();

    // Random traffic
    bus_write(3'd4, 32'h0F0);
    bus_write(3'd3, 32'h1FF);
    bus_write(3'd1, 32'd7);
    bus_write(3'd0, 32'h5);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, NUM_SRC - 1);
        SRC_IRQ[idx] = ~SRC_IRQ[idx];
      end
      INT_ACK = (INT === 1'b1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 4) == 0) begin
        DREQ  = 1;
        DRW   = 1'($urandom_range(0, 1));
        DADDR = 3'($urandom_range(0, 7));
        case (DADDR)
          3'd0:    WDATA = 32'($urandom_range(0, 7));
          3'd1:    WDATA = 32'($urandom_range(0, 20));
          default: WDATA = $urandom;
        endcase
      end else begin
        DREQ = 0;
      end
      step();
    end
    DREQ = 0; INT_ACK = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
